// File: rtl/dma_pkg.sv
// Shared constants, state types and helpers for the DMA configuration slave.
// Register offsets are decoded on the low 16 address bits only.
package dma_pkg;

   localparam logic [15:0] DMA_EN_OFS  = 16'h0100;
   localparam logic [15:0] DMA_SRC_OFS = 16'h0200;
   localparam logic [15:0] DMA_DST_OFS = 16'h0300;
   localparam logic [15:0] DMA_LEN_OFS = 16'h0400;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;
   typedef enum logic [2:0] {SEL_EN, SEL_SRC, SEL_DST, SEL_LEN, SEL_NONE} reg_sel_t;

   function automatic reg_sel_t decode_ofs(input logic [15:0] ofs);
      reg_sel_t sel;
      case (ofs)
         DMA_EN_OFS:  sel = SEL_EN;
         DMA_SRC_OFS: sel = SEL_SRC;
         DMA_DST_OFS: sel = SEL_DST;
         DMA_LEN_OFS: sel = SEL_LEN;
         default:     sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   // Byte-lane merge: lanes with a clear strobe keep their old contents.
   function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dma_cfg_slave_if.sv
// CPU-side AXI4-Lite-style bus carrying the DMA configuration accesses.
// Every channel transfers on a clock edge where VALID and READY are both high; VALID, once raised, holds with its payload stable until that edge.
interface dma_cfg_slave_if #(parameter int ID_W = 8);

   logic [ID_W-1:0] AWID_S;
   logic [31:0]     AWADDR_S;
   logic            AWVALID_S;
   logic            AWREADY_S;
   logic [31:0]     WDATA_S;
   logic [3:0]      WSTRB_S;
   logic            WVALID_S;
   logic            WREADY_S;
   logic [ID_W-1:0] BID_S;
   logic [1:0]      BRESP_S;
   logic            BVALID_S;
   logic            BREADY_S;
   logic [ID_W-1:0] ARID_S;
   logic [31:0]     ARADDR_S;
   logic            ARVALID_S;
   logic            ARREADY_S;
   logic [ID_W-1:0] RID_S;
   logic [31:0]     RDATA_S;
   logic [1:0]      RRESP_S;
   logic            RLAST_S;
   logic            RVALID_S;
   logic            RREADY_S;

   modport slave (
      input  AWID_S, AWADDR_S, AWVALID_S, WDATA_S, WSTRB_S, WVALID_S, BREADY_S,
             ARID_S, ARADDR_S, ARVALID_S, RREADY_S,
      output AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S,
             ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
   );

   modport master (
      output AWID_S, AWADDR_S, AWVALID_S, WDATA_S, WSTRB_S, WVALID_S, BREADY_S,
             ARID_S, ARADDR_S, ARVALID_S, RREADY_S,
      input  AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S,
             ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
   );

endinterface

// File: rtl/dma_cfg_slave.sv
// Configuration register slave for the DMA engine: EN/SRC/DST/LEN with independent
// single-outstanding write and read channels; EN self-clears on the engine's done pulse.
module dma_cfg_slave
   import dma_pkg::*;
#(
   parameter int ID_W   = 8,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   dma_cfg_slave_if.slave      bus,
   input  logic                dma_done,
   output logic                DMAEN,
   output logic [31:0]         DMASRC,
   output logic [31:0]         DMADST,
   output logic [31:0]         DMALEN,
   output wr_state_t           wr_state_dbg,
   output rd_state_t           rd_state_dbg
);

   if (DATA_W != 32) begin : g_bad_width
      $error("dma_cfg_slave supports DATA_W = 32 only");
   end

   wr_state_t       wr_state, wr_next;
   rd_state_t       rd_state, rd_next;
   logic            aw_ready_q, ar_ready_q;
   logic            w_ready, b_valid, r_valid;
   logic            aw_hs, w_hs, ar_hs;
   logic [15:0]     aw_ofs_q;
   logic [ID_W-1:0] bid_q, rid_q;
   logic [1:0]      bresp_q, rresp_q;
   logic [31:0]     rdata_q, r_value;
   logic            en_q;
   logic [31:0]     src_q, dst_q, len_q;
   reg_sel_t        w_sel, r_sel;
   logic            unused_addr_bits;

   assign aw_hs = bus.AWVALID_S & aw_ready_q;
   assign w_hs  = bus.WVALID_S & w_ready;
   assign ar_hs = bus.ARVALID_S & ar_ready_q;
   assign w_sel = decode_ofs(aw_ofs_q);
   assign r_sel = decode_ofs(bus.ARADDR_S[15:0]);
   assign unused_addr_bits = ^{bus.AWADDR_S[31:16], bus.ARADDR_S[31:16]};

   always_comb begin
      wr_next = wr_state;
      w_ready = 1'b0;
      b_valid = 1'b0;
      case (wr_state)
         W_IDLE: if (aw_hs) wr_next = W_DATA;
         W_DATA: begin
            w_ready = 1'b1;
            if (bus.WVALID_S) wr_next = W_RESP;
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (bus.BREADY_S) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      rd_next = rd_state;
      r_valid = 1'b0;
      case (rd_state)
         R_IDLE: if (ar_hs) rd_next = R_DATA;
         R_DATA: begin
            r_valid = 1'b1;
            if (bus.RREADY_S) rd_next = R_IDLE;
         end
         default: rd_next = R_IDLE;
      endcase
   end

   // Address readies are registered from the next state, so they rise one cycle after reset or a completed response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_state   <= W_IDLE;
         rd_state   <= R_IDLE;
         aw_ready_q <= 1'b0;
         ar_ready_q <= 1'b0;
      end else begin
         wr_state   <= wr_next;
         rd_state   <= rd_next;
         aw_ready_q <= (wr_next == W_IDLE);
         ar_ready_q <= (rd_next == R_IDLE);
      end
   end

   always_comb begin
      r_value = '0;
      case (r_sel)
         SEL_EN:  r_value = {31'b0, en_q};
         SEL_SRC: r_value = src_q;
         SEL_DST: r_value = dst_q;
         SEL_LEN: r_value = len_q;
         default: r_value = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_ofs_q <= '0;
         bid_q    <= '0;
         bresp_q  <= RESP_OKAY;
         rid_q    <= '0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_ofs_q <= bus.AWADDR_S[15:0];
            bid_q    <= bus.AWID_S;
         end
         if (w_hs) bresp_q <= (w_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
         if (ar_hs) begin
            rid_q   <= bus.ARID_S;
            rdata_q <= r_value;
            rresp_q <= (r_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   // The done clear comes first so a same-edge EN write overrides it; the lock uses the pre-edge EN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q  <= 1'b0;
         src_q <= '0;
         dst_q <= '0;
         len_q <= '0;
      end else begin
         if (dma_done) en_q <= 1'b0;
         if (w_hs) begin
            case (w_sel)
               SEL_EN:  if (bus.WSTRB_S[0]) en_q <= bus.WDATA_S[0];
               SEL_SRC: if (!en_q) src_q <= apply_strb(src_q, bus.WDATA_S, bus.WSTRB_S);
               SEL_DST: if (!en_q) dst_q <= apply_strb(dst_q, bus.WDATA_S, bus.WSTRB_S);
               SEL_LEN: if (!en_q) len_q <= apply_strb(len_q, bus.WDATA_S, bus.WSTRB_S);
               default: ;
            endcase
         end
      end
   end

   assign bus.AWREADY_S = aw_ready_q;
   assign bus.WREADY_S  = w_ready;
   assign bus.BVALID_S  = b_valid;
   assign bus.BID_S     = bid_q;
   assign bus.BRESP_S   = bresp_q;
   assign bus.ARREADY_S = ar_ready_q;
   assign bus.RVALID_S  = r_valid;
   assign bus.RLAST_S   = r_valid;
   assign bus.RID_S     = rid_q;
   assign bus.RDATA_S   = rdata_q;
   assign bus.RRESP_S   = rresp_q;

   assign DMAEN  = en_q;
   assign DMASRC = src_q;
   assign DMADST = dst_q;
   assign DMALEN = len_q;
   assign wr_state_dbg = wr_state;
   assign rd_state_dbg = rd_state;

endmodule

// File: tb/tb_dma_cfg_slave.sv
// Bench for dma_cfg_slave: directed scenarios plus randomized traffic checked
// against a register-level model of the programmer-visible behaviour.
module tb_dma_cfg_slave;
   import dma_pkg::*;

   localparam int ID_W = 8;

   logic            clk;
   logic            rst;
   logic            dma_done;
   logic            DMAEN;
   logic [31:0]     DMASRC, DMADST, DMALEN;
   wr_state_t       wr_state_dbg;
   rd_state_t       rd_state_dbg;
   int              tests_run;
   int              tests_failed;

   // Reference model of the programmer-visible registers
   logic            m_en;
   logic [31:0]     m_src, m_dst, m_len;

   dma_cfg_slave_if #(.ID_W(ID_W)) bus ();

   dma_cfg_slave #(.ID_W(ID_W), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .dma_done     (dma_done),
      .DMAEN        (DMAEN),
      .DMASRC       (DMASRC),
      .DMADST       (DMADST),
      .DMALEN       (DMALEN),
      .wr_state_dbg (wr_state_dbg),
      .rd_state_dbg (rd_state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic int m_decode(input logic [31:0] a);
      case (a[15:0])
         16'h0100: return 0;
         16'h0200: return 1;
         16'h0300: return 2;
         16'h0400: return 3;
         default:  return -1;
      endcase
   endfunction

   function automatic logic [31:0] m_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      return r;
   endfunction

   task automatic m_reset();
      m_en = 1'b0; m_src = '0; m_dst = '0; m_len = '0;
   endtask

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit done_same, output logic [1:0] resp);
      int idx;
      logic locked;
      idx    = m_decode(a);
      locked = m_en;
      resp   = (idx < 0) ? 2'b10 : 2'b00;
      if (done_same) m_en = 1'b0;
      case (idx)
         0: if (s[0]) m_en = d[0];
         1: if (!locked) m_src = m_merge(m_src, d, s);
         2: if (!locked) m_dst = m_merge(m_dst, d, s);
         3: if (!locked) m_len = m_merge(m_len, d, s);
         default: ;
      endcase
   endtask

   task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int idx;
      idx  = m_decode(a);
      resp = (idx < 0) ? 2'b10 : 2'b00;
      case (idx)
         0: d = {31'b0, m_en};
         1: d = m_src;
         2: d = m_dst;
         3: d = m_len;
         default: d = '0;
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit pulse_done, input int bp,
                           output logic [1:0] resp, output logic [ID_W-1:0] bid);
      bit ok;
      logic [1:0] resp0;
      resp = 2'b11; bid = '0;
      bus.AWID_S = id; bus.AWADDR_S = addr; bus.AWVALID_S = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = bus.AWREADY_S;
         @(posedge clk); #1;
      end
      bus.AWVALID_S = 1'b0;
      if (!ok) begin
         tests_run++; tests_failed++;
         $display("FAIL aw_timeout addr=%h got=no_awready exp=awready", addr);
         return;
      end
      bus.WDATA_S = data; bus.WSTRB_S = strb; bus.WVALID_S = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = bus.WREADY_S;
         if (ok && pulse_done) dma_done = 1'b1;
         @(posedge clk); #1;
         dma_done = 1'b0;
      end
      bus.WVALID_S = 1'b0;
      if (!ok) begin
         tests_run++; tests_failed++;
         $display("FAIL w_timeout addr=%h got=no_wready exp=wready", addr);
         return;
      end
      resp0 = bus.BRESP_S;
      for (int i = 0; i < bp; i++) begin
         bus.AWVALID_S = 1'b1;
         tests_run++;
         if (bus.BVALID_S !== 1'b1 || bus.BID_S !== id || bus.BRESP_S !== resp0 || bus.AWREADY_S !== 1'b0) begin
            tests_failed++;
            $display("FAIL b_hold cyc=%0d got bvalid=%b bid=%h bresp=%b awready=%b exp 1 %h %b 0",
                     i, bus.BVALID_S, bus.BID_S, bus.BRESP_S, bus.AWREADY_S, id, resp0);
         end
         @(posedge clk); #1;
      end
      bus.BREADY_S = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.BVALID_S === 1'b1) begin
            ok = 1'b1; bid = bus.BID_S; resp = bus.BRESP_S;
         end
         @(posedge clk); #1;
      end
      bus.BREADY_S = 1'b0; bus.AWVALID_S = 1'b0;
      if (!ok) begin
         tests_run++; tests_failed++;
         $display("FAIL b_timeout addr=%h got=no_bvalid exp=bvalid", addr);
      end
   endtask

   task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int bp,
                          output logic [31:0] data, output logic [1:0] resp, output logic [ID_W-1:0] rid);
      bit ok;
      logic [31:0] data0;
      data = '0; resp = 2'b11; rid = '0;
      bus.ARID_S = id; bus.ARADDR_S = addr; bus.ARVALID_S = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = bus.ARREADY_S;
         @(posedge clk); #1;
      end
      bus.ARVALID_S = 1'b0;
      if (!ok) begin
         tests_run++; tests_failed++;
         $display("FAIL ar_timeout addr=%h got=no_arready exp=arready", addr);
         return;
      end
      data0 = bus.RDATA_S;
      for (int i = 0; i < bp; i++) begin
         bus.ARVALID_S = 1'b1;
         tests_run++;
         if (bus.RVALID_S !== 1'b1 || bus.RLAST_S !== 1'b1 || bus.RDATA_S !== data0 ||
             bus.RID_S !== id || bus.ARREADY_S !== 1'b0) begin
            tests_failed++;
            $display("FAIL r_hold cyc=%0d got rvalid=%b rlast=%b rdata=%h rid=%h arready=%b exp 1 1 %h %h 0",
                     i, bus.RVALID_S, bus.RLAST_S, bus.RDATA_S, bus.RID_S, bus.ARREADY_S, data0, id);
         end
         @(posedge clk); #1;
      end
      bus.RREADY_S = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.RVALID_S === 1'b1) begin
            ok = 1'b1; data = bus.RDATA_S; resp = bus.RRESP_S; rid = bus.RID_S;
            tests_run++;
            if (bus.RLAST_S !== 1'b1) begin
               tests_failed++;
               $display("FAIL rlast got=%b exp=1", bus.RLAST_S);
            end
         end
         @(posedge clk); #1;
      end
      bus.RREADY_S = 1'b0; bus.ARVALID_S = 1'b0;
      if (!ok) begin
         tests_run++; tests_failed++;
         $display("FAIL r_timeout addr=%h got=no_rvalid exp=rvalid", addr);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S, bus.ARREADY_S, bus.RVALID_S, bus.RLAST_S} !== 6'b0 ||
          {bus.BID_S, bus.RID_S, bus.RDATA_S, bus.BRESP_S, bus.RRESP_S} !== '0 ||
          {DMAEN, DMASRC, DMADST, DMALEN} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs got awr=%b arr=%b rdata=%h en=%b src=%h exp all zero",
                  bus.AWREADY_S, bus.ARREADY_S, bus.RDATA_S, DMAEN, DMASRC);
      end
      rst = 1'b1;
      tests_run++;
      if (bus.AWREADY_S !== 1'b0) begin
         tests_failed++; $display("FAIL awready_at_release got=%b exp=0", bus.AWREADY_S);
      end
      @(posedge clk); #1;
      tests_run++;
      if (bus.AWREADY_S !== 1'b1 || bus.ARREADY_S !== 1'b1) begin
         tests_failed++;
         $display("FAIL ready_after_release got aw=%b ar=%b exp 1 1", bus.AWREADY_S, bus.ARREADY_S);
      end
   endtask

   task automatic test_program();
      logic [31:0] a[4];
      logic [31:0] d[4];
      logic [31:0] rd, exp_d;
      logic [1:0]  resp, exp_resp;
      logic [ID_W-1:0] id_o;
      a = '{32'h0000_0200, 32'h0000_0300, 32'h0000_0400, 32'h0000_0100};
      d = '{32'h0001_0000, 32'h0002_0000, 32'h0000_0040, 32'h0000_0001};
      for (int i = 0; i < 4; i++) begin
         m_write(a[i], d[i], 4'hF, 1'b0, exp_resp);
         do_write(ID_W'(8'h10 + i), a[i], d[i], 4'hF, 1'b0, 0, resp, id_o);
         tests_run++;
         if (resp !== exp_resp || id_o !== ID_W'(8'h10 + i) ||
             {DMAEN, DMASRC, DMADST, DMALEN} !== {m_en, m_src, m_dst, m_len}) begin
            tests_failed++;
            $display("FAIL program_%0d got resp=%b bid=%h en=%b src=%h dst=%h len=%h exp %b %h %b %h %h %h",
                     i, resp, id_o, DMAEN, DMASRC, DMADST, DMALEN, exp_resp, 8'h10 + i, m_en, m_src, m_dst, m_len);
         end
      end
      for (int i = 0; i < 4; i++) begin
         m_read(a[i], exp_d, exp_resp);
         do_read(ID_W'(8'h20 + i), a[i], 0, rd, resp, id_o);
         tests_run++;
         if (rd !== exp_d || resp !== exp_resp || id_o !== ID_W'(8'h20 + i)) begin
            tests_failed++;
            $display("FAIL readback_%0d got data=%h resp=%b rid=%h exp %h %b %h", i, rd, resp, id_o, exp_d, exp_resp, 8'h20 + i);
         end
      end
   endtask

   task automatic test_lock_done();
      logic [1:0] resp, exp_resp;
      logic [ID_W-1:0] id_o;
      m_write(32'h200, 32'hDEAD_BEEF, 4'hF, 1'b0, exp_resp);
      do_write(8'h31, 32'h200, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, resp, id_o);
      tests_run++;
      if (resp !== 2'b00 || DMASRC !== 32'h0001_0000 || DMASRC !== m_src) begin
         tests_failed++;
         $display("FAIL locked_src got resp=%b src=%h exp 00 %h", resp, DMASRC, m_src);
      end
      dma_done = 1'b1;
      @(posedge clk); #1;
      dma_done = 1'b0;
      m_en = 1'b0;
      tests_run++;
      if (DMAEN !== 1'b0) begin
         tests_failed++; $display("FAIL done_clears_en got=%b exp=0", DMAEN);
      end
      m_write(32'h200, 32'h0003_0000, 4'hF, 1'b0, exp_resp);
      do_write(8'h32, 32'h200, 32'h0003_0000, 4'hF, 1'b0, 0, resp, id_o);
      tests_run++;
      if (resp !== exp_resp || DMASRC !== m_src) begin
         tests_failed++; $display("FAIL unlocked_src got resp=%b src=%h exp %b %h", resp, DMASRC, exp_resp, m_src);
      end
   endtask

   task automatic test_done_collision();
      logic [1:0] resp, exp_resp;
      logic [ID_W-1:0] id_o;
      m_write(32'h100, 32'h1, 4'h1, 1'b0, exp_resp);
      do_write(8'h41, 32'h100, 32'h1, 4'h1, 1'b0, 0, resp, id_o);
      m_write(32'h100, 32'h1, 4'h1, 1'b1, exp_resp);
      do_write(8'h42, 32'h100, 32'h1, 4'h1, 1'b1, 0, resp, id_o);
      tests_run++;
      if (DMAEN !== 1'b1 || DMAEN !== m_en || resp !== exp_resp) begin
         tests_failed++; $display("FAIL collision_write_wins got en=%b resp=%b exp 1 %b", DMAEN, resp, exp_resp);
      end
      m_write(32'h100, 32'h1, 4'h0, 1'b1, exp_resp);
      do_write(8'h43, 32'h100, 32'h1, 4'h0, 1'b1, 0, resp, id_o);
      tests_run++;
      if (DMAEN !== 1'b0 || DMAEN !== m_en || resp !== exp_resp) begin
         tests_failed++; $display("FAIL collision_nostrb got en=%b resp=%b exp 0 %b", DMAEN, resp, exp_resp);
      end
   endtask

   task automatic test_decode_strobe();
      logic [31:0] rd;
      logic [1:0]  resp, exp_resp;
      logic [ID_W-1:0] id_o;
      m_write(32'h500, 32'h1234_5678, 4'hF, 1'b0, exp_resp);
      do_write(8'h51, 32'h500, 32'h1234_5678, 4'hF, 1'b0, 0, resp, id_o);
      tests_run++;
      if (resp !== 2'b10 || {DMAEN, DMASRC, DMADST, DMALEN} !== {m_en, m_src, m_dst, m_len}) begin
         tests_failed++; $display("FAIL bad_addr_write got resp=%b src=%h exp 10 %h", resp, DMASRC, m_src);
      end
      do_read(8'h52, 32'h500, 0, rd, resp, id_o);
      tests_run++;
      if (resp !== 2'b10 || rd !== 32'h0 || id_o !== 8'h52) begin
         tests_failed++; $display("FAIL bad_addr_read got resp=%b data=%h rid=%h exp 10 0 52", resp, rd, id_o);
      end
      m_write(32'h300, 32'h0, 4'hF, 1'b0, exp_resp);
      do_write(8'h53, 32'h300, 32'h0, 4'hF, 1'b0, 0, resp, id_o);
      m_write(32'h300, 32'hAABB_CCDD, 4'b0010, 1'b0, exp_resp);
      do_write(8'h54, 32'h300, 32'hAABB_CCDD, 4'b0010, 1'b0, 0, resp, id_o);
      tests_run++;
      if (DMADST !== 32'h0000_CC00 || DMADST !== m_dst || resp !== 2'b00) begin
         tests_failed++; $display("FAIL strobe_dst got dst=%h resp=%b exp 0000cc00 00", DMADST, resp);
      end
      m_write(32'h100, 32'h1, 4'h0, 1'b0, exp_resp);
      do_write(8'h55, 32'h100, 32'h1, 4'h0, 1'b0, 0, resp, id_o);
      tests_run++;
      if (DMAEN !== 1'b0 || resp !== 2'b00) begin
         tests_failed++; $display("FAIL en_nostrb got en=%b resp=%b exp 0 00", DMAEN, resp);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, exp_d;
      logic [1:0]  resp, exp_resp;
      logic [ID_W-1:0] id_o;
      m_write(32'h400, 32'h1234_5678, 4'hF, 1'b0, exp_resp);
      do_write(8'h61, 32'h400, 32'h1234_5678, 4'hF, 1'b0, 5, resp, id_o);
      tests_run++;
      if (resp !== exp_resp || id_o !== 8'h61 || DMALEN !== m_len) begin
         tests_failed++; $display("FAIL bp_write got resp=%b bid=%h len=%h exp %b 61 %h", resp, id_o, DMALEN, exp_resp, m_len);
      end
      m_read(32'h200, exp_d, exp_resp);
      do_read(8'h62, 32'h200, 5, rd, resp, id_o);
      tests_run++;
      if (rd !== exp_d || resp !== exp_resp || id_o !== 8'h62) begin
         tests_failed++; $display("FAIL bp_read got data=%h resp=%b rid=%h exp %h %b 62", rd, resp, id_o, exp_d, exp_resp);
      end
   endtask

   task automatic test_rw_same_cycle();
      logic [31:0] old_len, exp_new;
      logic [1:0]  exp_resp;
      @(posedge clk); #1;
      old_len = m_len;
      exp_new = old_len ^ 32'h0F0F_F0F0;
      bus.AWID_S = 8'h71; bus.AWADDR_S = 32'h400; bus.AWVALID_S = 1'b1;
      tests_run++;
      if (bus.AWREADY_S !== 1'b1) begin
         tests_failed++; $display("FAIL rw_idle_awready got=%b exp=1", bus.AWREADY_S);
      end
      @(posedge clk); #1;
      bus.AWVALID_S = 1'b0;
      bus.WDATA_S = exp_new; bus.WSTRB_S = 4'hF; bus.WVALID_S = 1'b1;
      bus.ARID_S = 8'h72; bus.ARADDR_S = 32'h400; bus.ARVALID_S = 1'b1;
      @(posedge clk); #1;
      bus.WVALID_S = 1'b0; bus.ARVALID_S = 1'b0;
      m_write(32'h400, exp_new, 4'hF, 1'b0, exp_resp);
      tests_run++;
      if (bus.RVALID_S !== 1'b1 || bus.RDATA_S !== old_len || bus.RID_S !== 8'h72) begin
         tests_failed++;
         $display("FAIL rw_read_old got rvalid=%b data=%h rid=%h exp 1 %h 72", bus.RVALID_S, bus.RDATA_S, bus.RID_S, old_len);
      end
      bus.BREADY_S = 1'b1; bus.RREADY_S = 1'b1;
      @(posedge clk); #1;
      bus.BREADY_S = 1'b0; bus.RREADY_S = 1'b0;
      tests_run++;
      if (DMALEN !== m_len || bus.BVALID_S !== 1'b0 || bus.RVALID_S !== 1'b0) begin
         tests_failed++; $display("FAIL rw_write_applied got len=%h exp %h", DMALEN, m_len);
      end
   endtask

   task automatic test_random();
      logic [31:0] addr, data, rd, exp_d;
      logic [3:0]  strb;
      logic [1:0]  resp, exp_resp;
      logic [ID_W-1:0] id, id_o;
      logic [15:0] lo;
      bit pulse;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0: lo = 16'h0100;
            1: lo = 16'h0200;
            2: lo = 16'h0300;
            3: lo = 16'h0400;
            default: begin
               lo = 16'($urandom_range(0, 16'hFFFF));
               if (m_decode({16'h0, lo}) >= 0) lo = 16'h0504;
            end
         endcase
         addr = {16'($urandom_range(0, 16'hFFFF)), lo};
         data = $urandom;
         strb = 4'($urandom_range(0, 15));
         id   = ID_W'($urandom_range(0, 255));
         pulse = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 1) == 1) begin
            m_write(addr, data, strb, pulse, exp_resp);
            do_write(id, addr, data, strb, pulse, 0, resp, id_o);
            tests_run++;
            if (resp !== exp_resp || id_o !== id ||
                {DMAEN, DMASRC, DMADST, DMALEN} !== {m_en, m_src, m_dst, m_len}) begin
               tests_failed++;
               $display("FAIL rand_write_%0d addr=%h got resp=%b bid=%h en=%b src=%h dst=%h len=%h exp %b %h %b %h %h %h",
                        n, addr, resp, id_o, DMAEN, DMASRC, DMADST, DMALEN, exp_resp, id, m_en, m_src, m_dst, m_len);
            end
         end else begin
            m_read(addr, exp_d, exp_resp);
            do_read(id, addr, 0, rd, resp, id_o);
            tests_run++;
            if (rd !== exp_d || resp !== exp_resp || id_o !== id) begin
               tests_failed++;
               $display("FAIL rand_read_%0d addr=%h got data=%h resp=%b rid=%h exp %h %b %h",
                        n, addr, rd, resp, id_o, exp_d, exp_resp, id);
            end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] rd;
      logic [1:0]  resp, exp_resp;
      logic [ID_W-1:0] id_o;
      dma_done = 1'b1;
      @(posedge clk); #1;
      dma_done = 1'b0;
      m_en = 1'b0;
      m_write(32'h200, 32'h0000_1234, 4'hF, 1'b0, exp_resp);
      do_write(8'h81, 32'h200, 32'h0000_1234, 4'hF, 1'b0, 0, resp, id_o);
      bus.AWID_S = 8'h5A; bus.AWADDR_S = 32'h300; bus.AWVALID_S = 1'b1;
      @(posedge clk); #1;
      bus.AWVALID_S = 1'b0;
      tests_run++;
      if (wr_state_dbg !== W_DATA || bus.WREADY_S !== 1'b1) begin
         tests_failed++; $display("FAIL midwr_in_wdata got state=%0d wready=%b exp %0d 1", wr_state_dbg, bus.WREADY_S, W_DATA);
      end
      bus.WDATA_S = 32'hFFFF_FFFF; bus.WSTRB_S = 4'hF; bus.WVALID_S = 1'b1;
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if ({bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S, bus.ARREADY_S, bus.RVALID_S, bus.RLAST_S} !== 6'b0 ||
          {bus.BID_S, bus.RID_S, bus.RDATA_S, bus.BRESP_S, bus.RRESP_S} !== '0 ||
          {DMAEN, DMASRC, DMADST, DMALEN} !== '0) begin
         tests_failed++;
         $display("FAIL midwr_async_clear got wready=%b bid=%h src=%h exp 0 0 0", bus.WREADY_S, bus.BID_S, DMASRC);
      end
      bus.WVALID_S = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tests_run++;
      if (bus.AWREADY_S !== 1'b0 || wr_state_dbg !== W_IDLE) begin
         tests_failed++; $display("FAIL midwr_release got awready=%b state=%0d exp 0 %0d", bus.AWREADY_S, wr_state_dbg, W_IDLE);
      end
      @(posedge clk); #1;
      tests_run++;
      if (bus.AWREADY_S !== 1'b1 || {DMAEN, DMASRC, DMADST, DMALEN} !== {m_en, m_src, m_dst, m_len}) begin
         tests_failed++; $display("FAIL midwr_after got awready=%b src=%h dst=%h exp 1 0 0", bus.AWREADY_S, DMASRC, DMADST);
      end
      do_read(8'h82, 32'h300, 0, rd, resp, id_o);
      tests_run++;
      if (rd !== m_dst || resp !== 2'b00) begin
         tests_failed++; $display("FAIL midwr_readback got data=%h resp=%b exp %h 00", rd, resp, m_dst);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      tests_run = 0; tests_failed = 0;
      rst = 1'b0; dma_done = 1'b0;
      bus.AWID_S = '0; bus.AWADDR_S = '0; bus.AWVALID_S = 1'b0;
      bus.WDATA_S = '0; bus.WSTRB_S = '0; bus.WVALID_S = 1'b0; bus.BREADY_S = 1'b0;
      bus.ARID_S = '0; bus.ARADDR_S = '0; bus.ARVALID_S = 1'b0; bus.RREADY_S = 1'b0;
      m_reset();
      test_reset();
      test_program();
      test_lock_done();
      test_done_collision();
      test_decode_strobe();
      test_backpressure();
      test_rw_same_cycle();
      test_random();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
